// File: rtl/inner_product_unit.sv
// inner_product_unit: sequential fixed-point multiply-accumulate engine.
// Walks element indices 0..last and reads one operand pair per cycle.
// The operands come through external muxes that are steered by elem_idx.
// Each signed product is scaled down by FRAC bits and accumulated onto a preset value.
//
// Handshake: the caller raises start. It is sampled only while IDLE, and dim, addSubs
// and resetvalue are latched in that same cycle. busy is high for the whole run.
// endflag is a one-cycle pulse that marks result as valid. result then holds its
// value until the next run completes. A start raised during a run is ignored.
module inner_product_unit #(
    parameter int nBits  = 32,
    parameter int FRAC   = 15,
    parameter int MAXLEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [nBits-1:0] dim,
    input  logic             addSubs,
    input  logic [nBits-1:0] resetvalue,
    input  logic [nBits-1:0] opA,
    input  logic [nBits-1:0] opB,
    output logic [nBits-1:0] elem_idx,
    output logic             busy,
    output logic [nBits-1:0] result,
    output logic             endflag,
    output logic             state_dbg
);

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t            state, state_n;
    logic [nBits-1:0]  acc, acc_n;
    logic [nBits-1:0]  last, last_n;
    logic              mode, mode_n;
    logic [nBits-1:0]  result_n, idx_n;
    logic              busy_n, end_n;

    // Sign-extended operands, so the product is formed at full double width.
    logic signed [2*nBits-1:0] op_a_ext, op_b_ext;
    logic [nBits-1:0]          prod, acc_sum;

    assign op_a_ext = {{nBits{opA[nBits-1]}}, opA};
    assign op_b_ext = {{nBits{opB[nBits-1]}}, opB};
    // Arithmetic shift floors toward minus infinity; then truncate to word width.
    assign prod     = nBits'((op_a_ext * op_b_ext) >>> FRAC);
    // Add or subtract the product; overflow wraps modulo 2**nBits.
    assign acc_sum  = mode ? (acc + prod) : (acc - prod);

    assign state_dbg = (state == ACC);

    // State and datapath registers; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            last     <= '0;
            mode     <= 1'b0;
            result   <= '0;
            elem_idx <= '0;
            busy     <= 1'b0;
            endflag  <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            last     <= last_n;
            mode     <= mode_n;
            result   <= result_n;
            elem_idx <= idx_n;
            busy     <= busy_n;
            endflag  <= end_n;
        end
    end

    // Next-state logic: accept a request in IDLE, then walk the elements in ACC.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        last_n   = last;
        mode_n   = mode;
        result_n = result;
        idx_n    = elem_idx;
        busy_n   = busy;
        end_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = resetvalue;
                    // Oversized lengths are clamped to the last supported index.
                    last_n  = (dim >= nBits'(MAXLEN)) ? nBits'(MAXLEN - 1) : dim;
                    mode_n  = addSubs;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = ACC;
                end
            end
            ACC: begin
                if (elem_idx == last) begin
                    result_n = acc_sum;
                    end_n    = 1'b1;
                    busy_n   = 1'b0;
                    idx_n    = '0;
                    state_n  = IDLE;
                end else begin
                    acc_n = acc_sum;
                    idx_n = elem_idx + nBits'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
